systolic_array_4x4_ctrl: RTL
============================

# systolic_array_4x4_ctrl

Sequencer for the 4x4 systolic array. Holds one 4x4 A operand (DATA_WIDTH words) and one 4x4 B operand (2*DATA_WIDTH words) written by the host. On `start` it streams both operands into the array as a diagonal wavefront, flushes the pipe with zeros, pulses the array's `result_ld`, then forwards four result rows with a valid strobe. Sits between the host/DMA write port and the array's FDi/RD/result_ld/sa_GD pins.

## Interface
- `DATA_WIDTH`, 16, A element width; B elements and results are 2*DATA_WIDTH.
- `FLUSH_CYCLES`, 6, zero-input cycles between the last wavefront beat and `result_ld`; legal range 1..15.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_wr_en`  in  1  write row `a_wr_row` of A.
- `a_wr_row`  in  2  A row index.
- `a_wr_data`  in  4*DATA_WIDTH  A[row][0..3], element 0 in LSBs.
- `b_wr_en`  in  1  write row `b_wr_row` of B.
- `b_wr_row`  in  2  B row index.
- `b_wr_data`  in  8*DATA_WIDTH  B[row][0..3], element 0 in LSBs.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result row.
- `wr_err`  out  1  one-cycle pulse when a write arrives while busy.
- `FDi0`, `FDi4`, `FDi8`, `FDi12`  out  DATA_WIDTH each  array left-edge A inputs, rows 0..3.
- `RD0`..`RD3`  out  2*DATA_WIDTH each  array top-edge B inputs, columns 0..3.
- `result_ld`  out  1  to array.
- `sa_GD0`..`sa_GD3`  in  2*DATA_WIDTH each  array result outputs.
- `res_data`  out  8*DATA_WIDTH  registered {GD3,GD2,GD1,GD0}.
- `res_row`  out  2  result row index.
- `res_valid`  out  1  `res_data`/`res_row` valid.

## Operation
- States: IDLE → FEED (7 cycles) → FLUSH (FLUSH_CYCLES) → LATCH (1) → DRAIN (4) → DONE (1) → IDLE.
- Step counter `f` is 0..6 in FEED and resets on each state entry.
- In FEED, FDi(4r) = A[r][f−r] when 0 ≤ f−r ≤ 3, else 0. RDc = B[f−c][c] when 0 ≤ f−c ≤ 3, else 0.
- All FDi/RD outputs are 0 in every state other than FEED.
- LATCH: `result_ld`=1 for exactly one cycle.
- DRAIN: the array presents result row k on sa_GD0..3 in DRAIN cycle k. The controller registers it and drives `res_valid`=1, `res_row`=k one cycle later.
- DONE: `done`=1. The last `res_valid` (row 3) coincides with `done`.
- Operand writes are accepted only while IDLE; operand buffers are not cleared by a run. A write while busy is dropped and `wr_err` pulses. Simultaneous A and B writes are both accepted.
- A write and `start` in the same IDLE cycle: the write is committed and the run uses the new data.
- `start` while busy is ignored with no error. `start` held high re-triggers on the IDLE cycle after DONE.
- Arithmetic is performed in the array; the controller only moves data and never truncates or extends.

## Timing
- `start` sampled at edge t → FEED cycles t+1..t+7, FLUSH t+8..t+7+FLUSH_CYCLES, LATCH next cycle.
- `res_valid` rows 0..3 on the 4 cycles after DRAIN starts + 1. `done` coincides with row 3.
- Total start-to-done latency = 13 + FLUSH_CYCLES cycles (19 by default).
- All outputs are registered.
- Reset values: state IDLE; busy, done, wr_err, result_ld, res_valid = 0; FDi*, RD*, res_data, res_row = 0; operand buffers = 0.
- Reset mid-run returns to IDLE immediately (asynchronous). All outputs go to their reset values and no `done` is produced.

## Structure
- Package `sa_ctrl_pkg`: state enum (IDLE, FEED, FLUSH, LATCH, DRAIN, DONE), `SA_N=4`, `FEED_LEN=2*SA_N-1`.
- Sub-module `sa_operand_buf`: parameterised 4-row register file with write port, reset clear, and a combinational skew-select read giving element [f−i][i]. Instantiated once for A and once for B.

## Test plan
- Reset check: assert `rst` → all outputs 0, busy=0.
- Identity: A=I, B[r][c]=4r+c+1, start → 19 cycles to `done`. FDi0 sequence 1,0,0,0,0,0,0. RD3 sequence 0,0,0,4,8,12,16. `result_ld` exactly once. `res_row` 0..3 with `res_valid` on 4 consecutive cycles.
- Busy protection: start, then a_wr_en at FEED f=2 → `wr_err` pulse, A buffer unchanged. A second `start` in FLUSH is ignored and only one `done` is produced.
- Same-cycle write+start: write A row 0 = {4,3,2,1} with start → FDi0 emits 1,2,3,4 on f=0..3.
- FLUSH_CYCLES=1: `done` 14 cycles after start. Held `start` → next FEED begins the cycle after IDLE is re-entered.
- Mid-run reset: assert `rst` at DRAIN row 1 → res_valid and result_ld drop at once, state IDLE. A new start runs a full clean sequence.

Source files
------------

// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the 4x4 systolic array sequencer.
//   SA_N     : array dimension (rows = columns)
//   FEED_LEN : beats in one diagonal wavefront (2*SA_N-1)
//   CNT_W    : width of the per-state step counter (covers FLUSH up to 15)
//   sa_state_t : sequencer states
package sa_ctrl_pkg;
    localparam int SA_N     = 4;
    localparam int FEED_LEN = 2 * SA_N - 1;
    localparam int CNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        LATCH,
        DRAIN,
        DONE
    } sa_state_t;
endpackage

// File: rtl/sa_operand_buf.sv
// 4-row operand register file with diagonal (skewed) read.
//   clk, rst  : clock, async active-high reset (clears contents)
//   wr_en/wr_row/wr_data : row write, element 0 in LSBs
//   f         : wavefront step
//   skew[i]   : element [f-i][i] (TRANSPOSE=0) or [i][f-i] (TRANSPOSE=1),
//               zero when f-i is outside 0..SA_N-1
// The read looks at the post-write contents so a row written in the same
// cycle the wavefront is launched is already visible to the first beat.
module sa_operand_buf
    import sa_ctrl_pkg::*;
#(
    parameter int W         = 16,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             wr_row,
    input  logic [SA_N*W-1:0]      wr_data,
    input  logic [2:0]             f,
    output logic [SA_N-1:0][W-1:0] skew
);
    logic [SA_N-1:0][SA_N-1:0][W-1:0] mem, mem_nx;

    always_comb begin
        mem_nx = mem;
        if (wr_en) mem_nx[wr_row] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem <= '0;
        else     mem <= mem_nx;
    end

    for (genvar i = 0; i < SA_N; i++) begin : g_lane
        logic [3:0]   d;   // f - i; negative values wrap to >= 12 and fail the range test
        logic [W-1:0] el;
        always_comb begin
            d  = {1'b0, f} - 4'(i);
            el = '0;
            if (d < 4'(SA_N))
                el = TRANSPOSE ? mem_nx[i][d[1:0]] : mem_nx[d[1:0]][i];
        end
        assign skew[i] = el;
    end
endmodule

// File: rtl/systolic_array_4x4_ctrl.sv
// Sequencer for the 4x4 systolic array.
//   Host side : a_wr_* / b_wr_* row writes (IDLE only, else wr_err pulse),
//               start, busy, done
//   Array side: FDi0/4/8/12 (A, left edge), RD0..3 (B, top edge), result_ld,
//               sa_GD0..3 (result row in)
//   Result    : res_data {GD3..GD0}, res_row, res_valid
// Every output is a register loaded from the *next* state, so each output
// lines up with the state it belongs to (FEED beat f shows beat f data).
module systolic_array_4x4_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_wr_en,
    input  logic [1:0]              a_wr_row,
    input  logic [4*DATA_WIDTH-1:0] a_wr_data,
    input  logic                    b_wr_en,
    input  logic [1:0]              b_wr_row,
    input  logic [8*DATA_WIDTH-1:0] b_wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_err,
    output logic [DATA_WIDTH-1:0]   FDi0,
    output logic [DATA_WIDTH-1:0]   FDi4,
    output logic [DATA_WIDTH-1:0]   FDi8,
    output logic [DATA_WIDTH-1:0]   FDi12,
    output logic [2*DATA_WIDTH-1:0] RD0,
    output logic [2*DATA_WIDTH-1:0] RD1,
    output logic [2*DATA_WIDTH-1:0] RD2,
    output logic [2*DATA_WIDTH-1:0] RD3,
    output logic                    result_ld,
    input  logic [2*DATA_WIDTH-1:0] sa_GD0,
    input  logic [2*DATA_WIDTH-1:0] sa_GD1,
    input  logic [2*DATA_WIDTH-1:0] sa_GD2,
    input  logic [2*DATA_WIDTH-1:0] sa_GD3,
    output logic [8*DATA_WIDTH-1:0] res_data,
    output logic [1:0]              res_row,
    output logic                    res_valid
);
    localparam int BW = 2 * DATA_WIDTH;

    sa_state_t                        state, state_nx;
    logic [CNT_W-1:0]                 cnt, cnt_nx;
    logic                             idle;
    logic [SA_N-1:0][DATA_WIDTH-1:0]  a_skew, fdi_q;
    logic [SA_N-1:0][BW-1:0]          b_skew, rd_q;

    assign idle = (state == IDLE);

    // Buffers only accept writes in IDLE; A is read row-wise along the
    // diagonal ([r][f-r]), B column-wise ([f-c][c]).
    sa_operand_buf #(.W(DATA_WIDTH), .TRANSPOSE(1'b1)) u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_wr_en & idle),
        .wr_row  (a_wr_row),
        .wr_data (a_wr_data),
        .f       (cnt_nx[2:0]),
        .skew    (a_skew)
    );

    sa_operand_buf #(.W(BW), .TRANSPOSE(1'b0)) u_b_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (b_wr_en & idle),
        .wr_row  (b_wr_row),
        .wr_data (b_wr_data),
        .f       (cnt_nx[2:0]),
        .skew    (b_skew)
    );

    // Next-state; the step counter restarts at 0 on every state entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = FEED;
            end
            FEED: if (cnt == CNT_W'(FEED_LEN - 1)) begin
                state_nx = FLUSH;
                cnt_nx   = '0;
            end
            FLUSH: if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                state_nx = LATCH;
                cnt_nx   = '0;
            end
            LATCH: begin
                state_nx = DRAIN;
                cnt_nx   = '0;
            end
            DRAIN: if (cnt == CNT_W'(SA_N - 1)) begin
                state_nx = DONE;
                cnt_nx   = '0;
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
            result_ld <= 1'b0;
            fdi_q     <= '0;
            rd_q      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_row   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            result_ld <= (state_nx == LATCH);
            wr_err    <= (a_wr_en | b_wr_en) & ~idle;
            fdi_q     <= (state_nx == FEED) ? a_skew : '0;
            rd_q      <= (state_nx == FEED) ? b_skew : '0;
            // Array shows row k during DRAIN beat k; forward it one cycle later.
            res_valid <= (state == DRAIN);
            if (state == DRAIN) begin
                res_data <= {sa_GD3, sa_GD2, sa_GD1, sa_GD0};
                res_row  <= cnt[1:0];
            end
        end
    end

    assign FDi0  = fdi_q[0];
    assign FDi4  = fdi_q[1];
    assign FDi8  = fdi_q[2];
    assign FDi12 = fdi_q[3];
    assign RD0   = rd_q[0];
    assign RD1   = rd_q[1];
    assign RD2   = rd_q[2];
    assign RD3   = rd_q[3];
endmodule
